// File: rtl/complex_row_vector_feeder.sv
// complex_row_vector_feeder
//   Initiator side of the row-by-vector interface. For each row of a job it
//   walks the chunks of that row through the matrix and vector RAMs, presents
//   each returned chunk pair to the complex row-by-vector unit with
//   start_row_by_vector, then waits for decoder_read_now and writes the
//   captured 64-bit complex result to the result RAM at the row index.
//
//   Optional feature macro: FEEDER_TIMEOUT_EN
//     defined   : a WAIT that lasts TIMEOUT cycles without decoder_read_now
//                 aborts the job with an err pulse (no write, no done).
//     undefined : WAIT is unbounded; err only flags an illegal n_chunks.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   go, n_rows, n_chunks   job start and size (sampled in IDLE while not busy)
//   mat_rd_addr/_data      matrix RAM read port, address {row,chunk}, 1-cycle latency
//   vec_rd_addr/_data      vector RAM read port, address chunk, 1-cycle latency
//   a_out, p_out           chunk operands to the row-by-vector unit
//   start_row_by_vector    operands valid this cycle
//   number_of_multiples    chunks per row of the current job
//   decoder_read_now       result-valid strobe from the row-by-vector unit
//   result                 row result, valid with decoder_read_now
//   res_wr_en/_addr/_data  result RAM write port
//   busy, done, err        job status; done/err are single-cycle pulses
module complex_row_vector_feeder #(
  parameter int unsigned ELEM_W = 64,
  parameter int unsigned UNITS  = 3,
  parameter int unsigned ROW_AW = 4,
  parameter int unsigned CHK_AW = 3
`ifdef FEEDER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic [ROW_AW:0]           n_rows,
  input  logic [CHK_AW:0]           n_chunks,
  output logic [ROW_AW+CHK_AW-1:0]  mat_rd_addr,
  output logic [CHK_AW-1:0]         vec_rd_addr,
  input  logic [UNITS*ELEM_W-1:0]   mat_rd_data,
  input  logic [UNITS*ELEM_W-1:0]   vec_rd_data,
  output logic [UNITS*ELEM_W-1:0]   a_out,
  output logic [UNITS*ELEM_W-1:0]   p_out,
  output logic                      start_row_by_vector,
  output logic [CHK_AW:0]           number_of_multiples,
  input  logic                      decoder_read_now,
  input  logic [ELEM_W-1:0]         result,
  output logic                      res_wr_en,
  output logic [ROW_AW-1:0]         res_wr_addr,
  output logic [ELEM_W-1:0]         res_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned DATA_W = UNITS * ELEM_W;

  // Largest legal chunk count (2^CHK_AW) and +1 constants at counter widths.
  localparam logic [CHK_AW:0] CHK_MAX = {1'b1, {CHK_AW{1'b0}}};
  localparam logic [CHK_AW:0] CHK_ONE = {{CHK_AW{1'b0}}, 1'b1};
  localparam logic [ROW_AW:0] ROW_ONE = {{ROW_AW{1'b0}}, 1'b1};

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned     TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic [ROW_AW-1:0]   row_q,     row_d;
  logic [CHK_AW-1:0]   chunk_q,   chunk_d;
  logic [ROW_AW:0]     rows_q,    rows_d;
  logic [CHK_AW:0]     nom_q,     nom_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                err_q,     err_d;
  logic                start_q,   start_d;
  logic [DATA_W-1:0]   a_hold_q,  a_hold_d;
  logic [DATA_W-1:0]   p_hold_q,  p_hold_d;
  logic                wr_en_q,   wr_en_d;
  logic [ROW_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [ELEM_W-1:0]   wr_data_q, wr_data_d;
`ifdef FEEDER_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q,     tmo_d;
`endif

  // Full-width successor indices so the last-index compares never wrap.
  logic [CHK_AW:0] chunk_nxt;
  logic [ROW_AW:0] row_nxt;
  logic            chunk_last;
  logic            row_last;

  assign chunk_nxt  = {1'b0, chunk_q} + CHK_ONE;
  assign row_nxt    = {1'b0, row_q} + ROW_ONE;
  assign chunk_last = (chunk_nxt == nom_q);
  // n_rows above 2^ROW_AW is treated as 2^ROW_AW rather than wrapping the index.
  assign row_last   = (row_nxt >= rows_q) || (&row_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    chunk_d   = chunk_q;
    rows_d    = rows_q;
    nom_d     = nom_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    a_hold_d  = start_q ? mat_rd_data : a_hold_q;
    p_hold_d  = start_q ? vec_rd_data : p_hold_q;
`ifdef FEEDER_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // busy is still high here for the cycle carrying done/err; go is
        // ignored until it has dropped.
        busy_d = 1'b0;
        if (go && !busy_q) begin
          if ((n_chunks == '0) || (n_chunks > CHK_MAX)) begin
            err_d = 1'b1;
          end else begin
            nom_d  = n_chunks;
            rows_d = n_rows;
            busy_d = 1'b1;
            if (n_rows == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_FETCH;
              row_d   = '0;
              chunk_d = '0;
            end
          end
        end
      end

      ST_FETCH: begin
        // The address held this cycle returns data next cycle, when the strobe fires.
        start_d = 1'b1;
        if (chunk_last) begin
          state_d = ST_WAIT;
`ifdef FEEDER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          chunk_d = chunk_nxt[CHK_AW-1:0];
        end
      end

      ST_WAIT: begin
        if (decoder_read_now) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_q;
          wr_data_d = result;
          if (row_last) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_FETCH;
            row_d   = row_nxt[ROW_AW-1:0];
            chunk_d = '0;
          end
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
`endif
      end

      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      chunk_q   <= '0;
      rows_q    <= '0;
      nom_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      a_hold_q  <= '0;
      p_hold_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef FEEDER_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      chunk_q   <= chunk_d;
      rows_q    <= rows_d;
      nom_q     <= nom_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      a_hold_q  <= a_hold_d;
      p_hold_q  <= p_hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef FEEDER_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign mat_rd_addr         = {row_q, chunk_q};
  assign vec_rd_addr         = chunk_q;
  assign start_row_by_vector = start_q;
  assign number_of_multiples = nom_q;
  assign res_wr_en           = wr_en_q;
  assign res_wr_addr         = wr_addr_q;
  assign res_wr_data         = wr_data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

  // RAM data arrives in the strobe cycle itself, so the strobe cycle passes it
  // straight through and the hold registers keep it stable between strobes.
  assign a_out = start_q ? mat_rd_data : a_hold_q;
  assign p_out = start_q ? vec_rd_data : p_hold_q;

endmodule
